// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam int X0_IDX = 0;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        FLUSH   = 2'd2
    } ctrl_state_t;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_MEMWAIT = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

endpackage

// File: rtl/pipe_hazard_ctrl_lu.sv
// rtl/pipe_hazard_ctrl_lu.sv - combinational load-use comparator (hazard_detect_lu)
module hazard_detect_lu
    import pipe_ctrl_pkg::*;
#(
    parameter int AW = 5
) (
    input  logic          memread,
    input  logic [AW-1:0] rd,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          load_use
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    always_comb begin
        load_use = memread && (rd != AW'(X0_IDX)) && ((rd == rs1) || (rd == rs2));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hold/flush controller; optional PIPE_PERF_CNT_EN perf counters
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = pipe_ctrl_pkg::REG_AW,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_ID,
    input  logic [REG_AW-1:0] rs2_ID,
    input  logic [REG_AW-1:0] rd_EX,
    input  logic              memread_EX,
    input  logic              branch_taken_MEM,
    input  logic              memread_MEM,
    input  logic              memwrite_MEM,
    input  logic              dmem_ready,
    output logic              stall_IF,
    output logic              stall_ID,
    output logic              stall_EX,
    output logic              stall_MEM,
    output logic              flush_IFID,
    output logic              flush_IDEX,
    output logic              flush_EXMEM,
    output logic              dmem_timeout,
    output logic [1:0]        ctrl_state
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cycles,
    output logic [15:0]       flush_events
`endif
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    logic [1:0]       state, next_state;
    logic [CNT_W-1:0] wait_cnt, next_cnt;
    logic             set_timeout;
    logic             mem_busy;
    logic             load_use;
    logic             run_like;
    logic             lu_en;
    logic             br_en;

    hazard_detect_lu #(.AW(REG_AW)) u_lu (
        .memread  (memread_EX),
        .rd       (rd_EX),
        .rs1      (rs1_ID),
        .rs2      (rs2_ID),
        .load_use (load_use)
    );

    // data memory still owes us a result this cycle
    always_comb begin
        mem_busy = (memread_MEM || memwrite_MEM) && !dmem_ready;
    end

    // hold/flush decode and next-state; MEMWAIT that resolves falls through to the RUN rules
    always_comb begin
        stall_IF    = 1'b0;
        stall_ID    = 1'b0;
        stall_EX    = 1'b0;
        stall_MEM   = 1'b0;
        flush_IFID  = 1'b0;
        flush_IDEX  = 1'b0;
        flush_EXMEM = 1'b0;
        next_state  = state;
        next_cnt    = wait_cnt;
        set_timeout = 1'b0;
        run_like    = 1'b0;
        lu_en       = 1'b0;
        br_en       = 1'b0;
        if (!reset) begin
            case (state)
                ST_RUN: begin
                    run_like = 1'b1;
                    lu_en    = 1'b1;
                    br_en    = 1'b1;
                end
                ST_FLUSH: begin
                    // ID and MEM hold bubbles after a flush; only a memory wait matters
                    run_like = 1'b1;
                end
                ST_MEMWAIT: begin
                    if (mem_busy) begin
                        if (wait_cnt == TIMEOUT_CNT) begin
                            set_timeout = 1'b1;
                            next_state  = ST_RUN;
                            next_cnt    = '0;
                        end else begin
                            stall_IF  = 1'b1;
                            stall_ID  = 1'b1;
                            stall_EX  = 1'b1;
                            stall_MEM = 1'b1;
                            next_cnt  = wait_cnt + CNT_W'(1);
                        end
                    end else begin
                        run_like = 1'b1;
                        lu_en    = 1'b1;
                        br_en    = 1'b1;
                        next_cnt = '0;
                    end
                end
                default: begin
                    next_state = ST_RUN;
                    next_cnt   = '0;
                end
            endcase

            if (run_like) begin
                if (mem_busy) begin
                    stall_IF   = 1'b1;
                    stall_ID   = 1'b1;
                    stall_EX   = 1'b1;
                    stall_MEM  = 1'b1;
                    next_state = ST_MEMWAIT;
                    next_cnt   = CNT_W'(1);
                end else if (br_en && branch_taken_MEM) begin
                    flush_IFID  = 1'b1;
                    flush_IDEX  = 1'b1;
                    flush_EXMEM = 1'b1;
                    next_state  = ST_FLUSH;
                end else begin
                    next_state = ST_RUN;
                    if (lu_en && load_use) begin
                        stall_IF   = 1'b1;
                        stall_ID   = 1'b1;
                        flush_IDEX = 1'b1;
                    end
                end
            end
        end
    end

    // state, wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            dmem_timeout <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
            if (set_timeout) begin
                dmem_timeout <= 1'b1;
            end
        end
    end

    assign ctrl_state = state;

`ifdef PIPE_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [15:0] flush_cnt_q;

    // saturating counts of stalled cycles and branch flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if ((stall_IF || stall_ID || stall_EX || stall_MEM) && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
            if (flush_EXMEM && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end
        end
    end

    assign stall_cycles = stall_cnt_q;
    assign flush_events = flush_cnt_q;
`endif

endmodule
